// File: rtl/wb_slave_bridge_if.sv
// rtl/wb_slave_bridge_if.sv - Wishbone-classic bus bundle between master and bridge
interface wb_slave_bridge_if #(
    parameter int DATA_W = 128,
    parameter int ADR_W  = 5
);
    logic              strobe;
    logic              we_i;
    logic [ADR_W-1:0]  adr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [DATA_W-1:0] wb_data_o;
    logic              ack_o;
    logic              err_o;

    modport master (
        output strobe, we_i, adr_i, wb_data_i,
        input  wb_data_o, ack_o, err_o
    );

    modport slave (
        input  strobe, we_i, adr_i, wb_data_i,
        output wb_data_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_slave_bridge.sv
// rtl/wb_slave_bridge.sv - Wishbone-classic slave decoding transfers into SD host core actions
module wb_slave_bridge #(
    parameter int DATA_W      = 128,
    parameter int ADR_W       = 5,
    parameter int NUM_REGS    = 16,
    parameter int CMD_ADR     = 16,
    parameter int FIFO_WR_ADR = 17,
    parameter int FIFO_RD_ADR = 18,
    parameter int DAT_ADR     = 19,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clock,
    input  logic              reset,
    wb_slave_bridge_if.slave  wb,
    input  logic [DATA_W-1:0] host_data_i,
    output logic [DATA_W-1:0] host_data_o,
    output logic [ADR_W-1:0]  adr_o,
    output logic              reg_read_en,
    output logic              reg_write_en,
    output logic              fifo_read_en,
    output logic              fifo_write_en,
    input  logic              fifo_full_i,
    input  logic              fifo_empty_i,
    output logic              new_command,
    output logic              new_data,
    input  logic              cmd_done_i,
    input  logic              data_done_i,
    output logic              busy_o
);

    // A zero timeout still needs a one-bit counter so the logic stays well formed.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, ACCESS, STALL, WAIT, RESP} state_t;
    typedef enum logic [2:0] {K_REG_RD, K_REG_WR, K_PUSH, K_POP, K_CMD, K_DAT, K_ILL} kind_t;

    state_t            state;
    kind_t             kind_q;
    kind_t             kind_in;
    kind_t             kind_sel;
    logic [ADR_W-1:0]  adr_q;
    logic [ADR_W-1:0]  adr_sel;
    logic [DATA_W-1:0] dat_q;
    logic [DATA_W-1:0] dat_sel;
    logic [DATA_W-1:0] hdat_sel;
    logic [5:0]        en_sel;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              blocked;
    logic              go_access;
    logic              done_hit;

    // Classify the transfer currently offered on the bus.
    always_comb begin
        kind_in = K_ILL;
        if (int'(wb.adr_i) < NUM_REGS) begin
            kind_in = wb.we_i ? K_REG_WR : K_REG_RD;
        end else if (wb.we_i && int'(wb.adr_i) == FIFO_WR_ADR) begin
            kind_in = K_PUSH;
        end else if (!wb.we_i && int'(wb.adr_i) == FIFO_RD_ADR) begin
            kind_in = K_POP;
        end else if (wb.we_i && int'(wb.adr_i) == CMD_ADR) begin
            kind_in = K_CMD;
        end else if (wb.we_i && int'(wb.adr_i) == DAT_ADR) begin
            kind_in = K_DAT;
        end
    end

    // In IDLE the access is launched straight from the bus; from STALL it comes from the latched copy.
    always_comb begin
        kind_sel = (state == IDLE) ? kind_in : kind_q;
        adr_sel  = (state == IDLE) ? wb.adr_i : adr_q;
        dat_sel  = (state == IDLE) ? wb.wb_data_i : dat_q;
        blocked  = (kind_sel == K_PUSH && fifo_full_i) || (kind_sel == K_POP && fifo_empty_i);
        hdat_sel = (kind_sel == K_REG_WR || kind_sel == K_PUSH || kind_sel == K_CMD) ? dat_sel : '0;
        en_sel   = '0;
        case (kind_sel)
            K_REG_RD: en_sel = 6'b000001;
            K_REG_WR: en_sel = 6'b000010;
            K_POP:    en_sel = 6'b000100;
            K_PUSH:   en_sel = 6'b001000;
            K_CMD:    en_sel = 6'b010000;
            K_DAT:    en_sel = 6'b100000;
            default:  en_sel = 6'b000000;
        endcase
        go_access = wb.strobe && !blocked &&
                    ((state == IDLE && kind_in != K_ILL) || state == STALL);
        tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
        done_hit  = (kind_q == K_CMD) ? cmd_done_i : data_done_i;
    end

    // Transfer FSM; every output is a register and pulse outputs default low each cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            kind_q        <= K_ILL;
            adr_q         <= '0;
            dat_q         <= '0;
            tmo_cnt       <= '0;
            busy_o        <= 1'b0;
            adr_o         <= '0;
            host_data_o   <= '0;
            reg_read_en   <= 1'b0;
            reg_write_en  <= 1'b0;
            fifo_read_en  <= 1'b0;
            fifo_write_en <= 1'b0;
            new_command   <= 1'b0;
            new_data      <= 1'b0;
            wb.ack_o      <= 1'b0;
            wb.err_o      <= 1'b0;
            wb.wb_data_o  <= '0;
        end else begin
            reg_read_en   <= 1'b0;
            reg_write_en  <= 1'b0;
            fifo_read_en  <= 1'b0;
            fifo_write_en <= 1'b0;
            new_command   <= 1'b0;
            new_data      <= 1'b0;
            wb.ack_o      <= 1'b0;
            wb.err_o      <= 1'b0;

            case (state)
                IDLE: begin
                    if (wb.strobe) begin
                        kind_q <= kind_in;
                        adr_q  <= wb.adr_i;
                        dat_q  <= wb.wb_data_i;
                        if (kind_in == K_ILL) begin
                            wb.err_o     <= 1'b1;
                            wb.wb_data_o <= '0;
                            state        <= RESP;
                        end else if (blocked) begin
                            busy_o  <= 1'b1;
                            tmo_cnt <= '0;
                            state   <= STALL;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (kind_q == K_REG_RD || kind_q == K_POP) begin
                        wb.wb_data_o <= host_data_i;
                    end else begin
                        wb.wb_data_o <= '0;
                    end
                    if (kind_q == K_CMD || kind_q == K_DAT) begin
                        busy_o  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end else begin
                        wb.ack_o <= 1'b1;
                        state    <= RESP;
                    end
                end

                STALL: begin
                    if (!wb.strobe) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (!blocked) begin
                        busy_o <= 1'b0;
                        state  <= ACCESS;
                    end else if (tmo_hit) begin
                        busy_o       <= 1'b0;
                        wb.err_o     <= 1'b1;
                        wb.wb_data_o <= '0;
                        state        <= RESP;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                WAIT: begin
                    if (done_hit) begin
                        busy_o   <= 1'b0;
                        wb.ack_o <= 1'b1;
                        state    <= RESP;
                    end else if (tmo_hit) begin
                        busy_o       <= 1'b0;
                        wb.err_o     <= 1'b1;
                        wb.wb_data_o <= '0;
                        state        <= RESP;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                RESP: begin
                    wb.wb_data_o <= '0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Launching an access drives exactly one strobe plus the address/data toward the host.
            if (go_access) begin
                {new_data, new_command, fifo_write_en, fifo_read_en, reg_write_en, reg_read_en} <= en_sel;
                adr_o       <= adr_sel;
                host_data_o <= hdat_sel;
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_bridge.sv
// tb/tb_wb_slave_bridge.sv - scoreboard bench for wb_slave_bridge
module tb_wb_slave_bridge;
    localparam int DW  = 128;
    localparam int AW  = 5;
    localparam int TMO = 32;

    localparam logic [5:0] EN_RR   = 6'b000001;
    localparam logic [5:0] EN_RW   = 6'b000010;
    localparam logic [5:0] EN_POP  = 6'b000100;
    localparam logic [5:0] EN_PUSH = 6'b001000;
    localparam logic [5:0] EN_CMD  = 6'b010000;
    localparam logic [5:0] EN_DAT  = 6'b100000;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] host_data_i;
    logic [DW-1:0] host_data_o;
    logic [AW-1:0] adr_o;
    logic          reg_read_en, reg_write_en, fifo_read_en, fifo_write_en;
    logic          fifo_full_i, fifo_empty_i;
    logic          new_command, new_data;
    logic          cmd_done_i, data_done_i;
    logic          busy_o;

    wb_slave_bridge_if #(.DATA_W(DW), .ADR_W(AW)) bus ();

    wb_slave_bridge #(.DATA_W(DW), .ADR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clock(clock), .reset(reset), .wb(bus),
        .host_data_i(host_data_i), .host_data_o(host_data_o), .adr_o(adr_o),
        .reg_read_en(reg_read_en), .reg_write_en(reg_write_en),
        .fifo_read_en(fifo_read_en), .fifo_write_en(fifo_write_en),
        .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
        .new_command(new_command), .new_data(new_data),
        .cmd_done_i(cmd_done_i), .data_done_i(data_done_i), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    typedef struct { int cyc; logic [5:0] en; logic [AW-1:0] adr; logic [DW-1:0] hd; } ev_t;
    typedef struct { int cyc; logic [1:0] re; logic [DW-1:0] rd; } rsp_t;

    ev_t  evq[$];
    rsp_t rsq[$];
    bit   busy_map[int];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_on = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT shows an output or one is due.
    always @(negedge clock) begin
        logic [5:0] en_v;
        logic [1:0] re_v;
        ev_t        e;
        rsp_t       r;
        if (mon_on) begin
            en_v = {new_data, new_command, fifo_write_en, fifo_read_en, reg_write_en, reg_read_en};
            if (en_v != 6'd0 || (evq.size() > 0 && evq[0].cyc == cyc)) begin
                if (evq.size() == 0) begin
                    chk("unexpected_enable", 128'(en_v), 128'(0));
                end else begin
                    e = evq.pop_front();
                    chk("enable_cycle", 128'(cyc), 128'(e.cyc));
                    chk("enable_kind", 128'(en_v), 128'(e.en));
                    chk("adr_o", 128'(adr_o), 128'(e.adr));
                    chk("host_data_o", host_data_o, e.hd);
                end
            end
            re_v = {bus.err_o, bus.ack_o};
            if (re_v != 2'd0 || (rsq.size() > 0 && rsq[0].cyc == cyc)) begin
                if (rsq.size() == 0) begin
                    chk("unexpected_resp", 128'(re_v), 128'(0));
                end else begin
                    r = rsq.pop_front();
                    chk("resp_cycle", 128'(cyc), 128'(r.cyc));
                    chk("resp_err_ack", 128'(re_v), 128'(r.re));
                    chk("wb_data_o", bus.wb_data_o, r.rd);
                end
            end
            chk("busy_o", 128'(busy_o), 128'(busy_map.exists(cyc)));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.strobe    = 1'b0;
            bus.we_i      = 1'($urandom_range(0, 1));
            bus.adr_i     = AW'($urandom_range(0, 31));
            bus.wb_data_i = rnd128();
            fifo_full_i   = 1'($urandom_range(0, 1));
            fifo_empty_i  = 1'($urandom_range(0, 1));
            cmd_done_i    = 1'($urandom_range(0, 1));
            data_done_i   = 1'($urandom_range(0, 1));
            host_data_i   = rnd128();
            tick();
        end
    endtask

    // One transfer: outcome derived from the decode rules and cycle arithmetic, then driven.
    task automatic run_txn(input bit we, input int adr, input logic [DW-1:0] d,
                           input int n, input int a, input int dd, input bit drop);
        int s, ev_c, rs_c, end_c, k, dcyc;
        logic [5:0] en;
        logic [DW-1:0] hd, hout, rdat;
        bit has_ev, has_rs, rs_err, aborting, is_fifo;
        s = cyc;
        hd = rnd128();
        if (adr < 16)               en = we ? EN_RW : EN_RR;
        else if (we && adr == 17)   en = EN_PUSH;
        else if (!we && adr == 18)  en = EN_POP;
        else if (we && adr == 16)   en = EN_CMD;
        else if (we && adr == 19)   en = EN_DAT;
        else                        en = 6'd0;
        is_fifo = (en == EN_PUSH || en == EN_POP);
        dcyc = -1; has_ev = 1'b0; has_rs = 1'b1; rs_err = 1'b0; aborting = 1'b0;
        ev_c = -1; rs_c = -1; end_c = s + 1;
        if (en == 6'd0) begin
            rs_err = 1'b1; rs_c = s + 1; end_c = s + 1;
        end else if (is_fifo && n > 0) begin
            k = (n > TMO) ? TMO : n;
            if (a >= 1 && a <= k) begin
                aborting = 1'b1; has_rs = 1'b0; end_c = s + a;
                for (int c = s + 1; c <= s + a; c++) busy_map[c] = 1'b1;
            end else if (n > TMO) begin
                for (int c = s + 1; c <= s + TMO; c++) busy_map[c] = 1'b1;
                rs_err = 1'b1; rs_c = s + TMO + 1; end_c = rs_c;
            end else begin
                for (int c = s + 1; c <= s + n; c++) busy_map[c] = 1'b1;
                has_ev = 1'b1; ev_c = s + n + 1; rs_c = s + n + 2; end_c = rs_c;
            end
        end else if (en == EN_CMD || en == EN_DAT) begin
            has_ev = 1'b1; ev_c = s + 1;
            if (dd <= TMO - 1) begin
                dcyc = s + 2 + dd; rs_c = dcyc + 1;
            end else begin
                rs_err = 1'b1; rs_c = s + TMO + 2;
            end
            for (int c = s + 2; c < rs_c; c++) busy_map[c] = 1'b1;
            end_c = rs_c;
        end else begin
            has_ev = 1'b1; ev_c = s + 1; rs_c = s + 2; end_c = rs_c;
        end
        hout = (en == EN_RW || en == EN_PUSH || en == EN_CMD) ? d : '0;
        rdat = (!rs_err && (en == EN_RR || en == EN_POP)) ? hd : '0;
        if (has_ev) evq.push_back('{ev_c, en, AW'(adr), hout});
        if (has_rs) rsq.push_back('{rs_c, rs_err ? 2'b10 : 2'b01, rdat});

        for (int c = s; c <= end_c; c++) begin
            bus.strobe = 1'b1;
            if (aborting && c == s + a) bus.strobe = 1'b0;
            if ((en == EN_CMD || en == EN_DAT) && drop && c >= s + 2) bus.strobe = 1'b0;
            if (c == s) begin
                bus.we_i = we; bus.adr_i = AW'(adr); bus.wb_data_i = d;
            end else begin
                bus.we_i = 1'($urandom_range(0, 1));
                bus.adr_i = AW'($urandom_range(0, 31));
                bus.wb_data_i = rnd128();
            end
            fifo_full_i  = (en == EN_PUSH) ? (c < s + n) : 1'($urandom_range(0, 1));
            fifo_empty_i = (en == EN_POP)  ? (c < s + n) : 1'($urandom_range(0, 1));
            if (en == EN_CMD) begin
                cmd_done_i  = (c == dcyc);
                data_done_i = ($urandom_range(0, 2) == 0);
            end else if (en == EN_DAT) begin
                data_done_i = (c == dcyc);
                cmd_done_i  = ($urandom_range(0, 2) == 0);
            end else begin
                cmd_done_i  = ($urandom_range(0, 3) == 0);
                data_done_i = ($urandom_range(0, 3) == 0);
            end
            host_data_i = (has_ev && c == ev_c) ? hd : rnd128();
            tick();
        end
    endtask

    // Reset lands while a command waits for completion; the late done must be ignored.
    task automatic reset_in_wait();
        int s;
        logic [DW-1:0] d;
        s = cyc;
        d = rnd128();
        evq.push_back('{s + 1, EN_CMD, AW'(16), d});
        busy_map[s + 2] = 1'b1;
        busy_map[s + 3] = 1'b1;
        bus.strobe = 1'b1; bus.we_i = 1'b1; bus.adr_i = AW'(16); bus.wb_data_i = d;
        cmd_done_i = 1'b0; data_done_i = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        bus.strobe = 1'b0;
        cmd_done_i = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_host_data_o", host_data_o, 128'(0));
        chk("rst_adr_o", 128'(adr_o), 128'(0));
        chk("rst_wb_data_o", bus.wb_data_o, 128'(0));
        tick();
        cmd_done_i = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.strobe = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.wb_data_i = '0;
        host_data_i = '0; fifo_full_i = 1'b0; fifo_empty_i = 1'b0;
        cmd_done_i = 1'b0; data_done_i = 1'b0;
        tick(); tick(); tick();
        chk("reset_enables", 128'({new_data, new_command, fifo_write_en, fifo_read_en,
                                   reg_write_en, reg_read_en}), 128'(0));
        chk("reset_ack_err_busy", 128'({bus.ack_o, bus.err_o, busy_o}), 128'(0));
        chk("reset_adr_o", 128'(adr_o), 128'(0));
        chk("reset_host_data_o", host_data_o, 128'(0));
        chk("reset_wb_data_o", bus.wb_data_o, 128'(0));
        reset = 1'b0;
        mon_on = 1'b1;
        idle(2);

        run_txn(1'b1, 3, {16{8'hA5}}, 0, 0, 0, 1'b0);
        run_txn(1'b0, 7, rnd128(), 0, 0, 0, 1'b0);
        idle(1);
        run_txn(1'b0, 18, rnd128(), 5, 0, 0, 1'b0);
        run_txn(1'b1, 17, rnd128(), 3, 0, 0, 1'b0);
        run_txn(1'b1, 16, rnd128(), 0, 0, 18, 1'b0);
        run_txn(1'b1, 19, rnd128(), 0, 0, TMO + 3, 1'b1);
        run_txn(1'b1, 19, rnd128(), 0, 0, TMO - 1, 1'b0);
        run_txn(1'b0, 16, rnd128(), 0, 0, 0, 1'b0);
        run_txn(1'b1, 25, rnd128(), 0, 0, 0, 1'b0);
        run_txn(1'b1, 18, rnd128(), 0, 0, 0, 1'b0);
        run_txn(1'b1, 17, rnd128(), TMO + 2, 0, 0, 1'b0);
        run_txn(1'b0, 18, rnd128(), TMO, 0, 0, 1'b0);
        run_txn(1'b0, 18, rnd128(), 10, 4, 0, 1'b0);
        idle(2);
        reset_in_wait();
        run_txn(1'b1, 5, rnd128(), 0, 0, 0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            int r, adr, n, a, dd;
            bit we, drop;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: begin adr = $urandom_range(0, 15); we = 1'($urandom_range(0, 1)); end
                3:       begin adr = 17; we = 1'b1; end
                4:       begin adr = 18; we = 1'b0; end
                5:       begin adr = 16; we = 1'b1; end
                6:       begin adr = 19; we = 1'b1; end
                default: begin adr = $urandom_range(0, 31); we = 1'($urandom_range(0, 1)); end
            endcase
            n    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, TMO + 4);
            a    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TMO) : 0;
            dd   = $urandom_range(0, TMO + 3);
            drop = 1'($urandom_range(0, 1));
            run_txn(we, adr, rnd128(), n, a, dd, drop);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("event_queue_drained", 128'(evq.size()), 128'(0));
        chk("resp_queue_drained", 128'(rsq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
